cnn_frame_reader: RTL

- Downstream consumer of the event-to-QVGA double-buffered frame store.
- After a frame swap it scans the frozen (read-side) buffer in row-major order by driving read coordinates. It captures the returned pos/neg bits, packs them into 16-bit words for the CNN input stream, and pulses the done signal so the frame store can clear the buffer.
- Read-side latency is fixed. The block tracks its own requests through a delay line and does not count upstream valid pulses.

---
 rtl/cnn_frame_reader.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/cnn_frame_reader.sv
// Scans the frozen read-side frame buffer in row-major order and packs the
// returned pos/neg pixel bits into words for the CNN input stream.
module cnn_frame_reader #(
  parameter int RD_LAT       = 2,
  parameter int PIX_PER_WORD = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [8:0]                image_cols,
  input  logic [7:0]                image_rows,
  output logic [8:0]                cnn_read_x,
  output logic [7:0]                cnn_read_y,
  output logic                      rd_req,
  input  logic                      cnn_read_valid,
  input  logic                      raw_data_pos,
  input  logic                      raw_data_neg,
  output logic [2*PIX_PER_WORD-1:0] out_data,
  output logic                      out_valid,
  output logic                      out_last,
  input  logic                      out_ready,
  output logic                      cnn_done,
  output logic                      busy,
  output logic                      rd_err
);
  localparam int OW = 2 * PIX_PER_WORD;
  localparam int CW = $clog2(PIX_PER_WORD + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PUSH, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [8:0]      cols_q, cols_d, x_q, x_d, last_x_q, last_x_d;
  logic [7:0]      rows_q, rows_d, y_q, y_d, last_y_q, last_y_d;
  logic [CW-1:0]   issued_q, issued_d, returned_q, returned_d;
  logic            frame_end_q, frame_end_d;
  logic [OW-1:0]   pack_q, pack_d, out_data_q, out_data_d;
  logic [RD_LAT-1:0] dly_q, dly_d;
  logic            out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic            done_q, done_d, rd_err_q, rd_err_d;

  logic x_end, last_in_frame, last_in_word, accept, fire, tap;

  assign x_end         = (x_q == cols_q - 9'd1);
  assign last_in_frame = x_end && (y_q == rows_q - 8'd1);
  assign last_in_word  = (issued_q == CW'(PIX_PER_WORD - 1));
  assign accept        = out_valid_q && out_ready;
  assign fire          = !out_valid_q || out_ready;
  assign tap           = dly_q[RD_LAT-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cols_q      <= '0;
      rows_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      last_x_q    <= '0;
      last_y_q    <= '0;
      issued_q    <= '0;
      returned_q  <= '0;
      frame_end_q <= 1'b0;
      pack_q      <= '0;
      dly_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cols_q      <= cols_d;
      rows_q      <= rows_d;
      x_q         <= x_d;
      y_q         <= y_d;
      last_x_q    <= last_x_d;
      last_y_q    <= last_y_d;
      issued_q    <= issued_d;
      returned_q  <= returned_d;
      frame_end_q <= frame_end_d;
      pack_q      <= pack_d;
      dly_q       <= dly_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
      rd_err_q    <= rd_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (last_in_word || last_in_frame) state_d = WAIT;
      WAIT:    if (returned_q == issued_q) state_d = PUSH;
      PUSH:    if (fire) state_d = frame_end_q ? FLUSH : ISSUE;
      FLUSH:   if (accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cols_d      = cols_q;
    rows_d      = rows_q;
    x_d         = x_q;
    y_d         = y_q;
    last_x_d    = last_x_q;
    last_y_d    = last_y_q;
    issued_d    = issued_q;
    returned_d  = returned_q;
    frame_end_d = frame_end_q;
    pack_d      = pack_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    done_d      = (state_q == FLUSH) && accept;
    rd_err_d    = rd_err_q;

    // Request tracking: the tap marks the cycle our own read returns.
    dly_d[0] = (state_q == ISSUE);
    for (int k = 1; k < RD_LAT; k++) dly_d[k] = dly_q[k-1];

    if (tap) begin
      for (int k = 0; k < PIX_PER_WORD; k++) begin
        if (returned_q == CW'(k))
          pack_d[2*k +: 2] = cnn_read_valid ? {raw_data_pos, raw_data_neg} : 2'b00;
      end
      returned_d = returned_q + CW'(1);
      if (!cnn_read_valid) rd_err_d = 1'b1;
    end

    if (accept) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          cols_d      = image_cols;
          rows_d      = image_rows;
          x_d         = '0;
          y_d         = '0;
          issued_d    = '0;
          returned_d  = '0;
          frame_end_d = 1'b0;
          pack_d      = '0;
          rd_err_d    = 1'b0;
        end
      end
      ISSUE: begin
        issued_d = issued_q + CW'(1);
        last_x_d = x_q;
        last_y_d = y_q;
        if (x_end) begin
          x_d = '0;
          y_d = y_q + 8'd1;
        end else begin
          x_d = x_q + 9'd1;
        end
        if (last_in_frame) frame_end_d = 1'b1;
      end
      PUSH: begin
        // Unfilled slots of a partial last word are already zero.
        if (fire) begin
          out_data_d  = pack_q;
          out_valid_d = 1'b1;
          out_last_d  = frame_end_q;
          pack_d      = '0;
          issued_d    = '0;
          returned_d  = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_req     = (state_q == ISSUE);
    cnn_read_x = rd_req ? x_q : last_x_q;
    cnn_read_y = rd_req ? y_q : last_y_q;
    out_data   = out_data_q;
    out_valid  = out_valid_q;
    out_last   = out_last_q;
    cnn_done   = done_q;
    busy       = (state_q != IDLE);
    rd_err     = rd_err_q;
  end
endmodule
